uart_tx: RTL
============

# uart_tx

Serial transmitter that drains the transmit FIFO and sends each word as an asynchronous UART frame: start bit, DBIT data bits LSB first, then a stop period. It sits on the read side of the TX FIFO. It consumes `empty` and `r_data`, issues one-cycle `rd` pops, and times every bit from the shared 16x-oversampling baud tick.

## Interface
- `DBIT`, default 8: data bits per frame (6..9).
- `SB_TICK`, default 16: stop-period length in baud ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- `clk`  in  1: system clock; all state is updated on its rising edge.
- `reset`  in  1: one clock; reset is asynchronous and active-low (`reset`=0 resets).
- `s_tick`  in  1: one-`clk`-wide pulse at 16x the baud rate, from the baud generator.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_r_data`  in  DBIT: FIFO head word; valid combinationally whenever `fifo_empty`=0.
- `fifo_rd`  out  1: pop strobe to the FIFO, exactly one cycle per word.
- `tx`  out  1: serial line output; registered, idle high.
- `tx_busy`  out  1: high whenever the state is not IDLE.
- `tx_done_tick`  out  1: one-cycle pulse marking the end of the stop period.

## Operation
States and transitions:
- **IDLE**
  - `tx`=1.
  - `s_tick` is ignored.
  - When `fifo_empty`=0:
    - `fifo_rd`=1 (combinational, `(state==IDLE) & ~fifo_empty`).
    - `fifo_r_data` is loaded into shift register `b`.
    - Tick counter `s` is cleared.
    - Next state is START.
- **START**
  - `tx`=0.
  - On each `s_tick`: if `s`==15, set `s`=0, bit counter `n`=0 and go to DATA; otherwise increment `s`.
- **DATA**
  - `tx`=`b[0]`.
  - On each `s_tick` with `s`==15: set `s`=0 and shift `b` right by one.
    - If `n`==DBIT-1, go to STOP; otherwise increment `n`.
  - On other `s_tick`s, increment `s`.
- **STOP**
  - `tx`=1.
  - On the `s_tick` where `s`==SB_TICK-1: `tx_done_tick`=1 in that cycle and next state is IDLE.
  - On other `s_tick`s, increment `s`.

Widths and register rules:
- `s` is wide enough to hold SB_TICK-1 (5 bits for defaults).
- `n` is clog2(DBIT) bits.
- `tx` is driven by a register whose next value is the value the next state requires, so the line never glitches.
- `fifo_rd` is never asserted outside IDLE, even if `fifo_empty` goes low mid-frame.
- A word is popped only when the block commits to sending it.

## Timing
Reset values:
- state=IDLE.
- `tx`=1, `tx_busy`=0, `tx_done_tick`=0.
- `s`=0, `n`=0, `b`=0.
- `fifo_rd`=0 when `fifo_empty`=1.

Latency:
- Pop at cycle c: `tx` falls at the edge ending c, so it reads low from cycle c+1.
- Frame length is (16·(1+DBIT) + SB_TICK) `s_tick` periods. For the defaults this is 160 ticks.
- Each bit period is counted from the first `s_tick` after entering the state.

Back-to-back frames:
- `tx_done_tick` is asserted in cycle d.
- IDLE is active in cycle d+1. If `fifo_empty`=0 there, `fifo_rd`=1 in d+1.
- Between frames the line is high for exactly one `clk` plus the remainder of the stop period.

Boundary conditions:
- **`s_tick` stuck low:** state and counters freeze, and `tx` holds its value.
- **Reset mid-frame:** `tx`→1 and `tx_busy`→0 immediately. The popped word is dropped and not re-sent.
- **`fifo_empty` rising in the same cycle as `fifo_rd`:** no effect. The pop has already occurred, and the data was latched the same edge.
- **Simultaneous `s_tick` and the pop cycle:** the tick is not counted. START's count begins on the next tick.

## Test plan
1. **Reset.** Hold `reset`=0 with `fifo_empty`=1 and `s_tick` toggling → `tx`=1, `tx_busy`=0, `fifo_rd`=0, `tx_done_tick`=0 throughout. After release, the block stays idle.
2. **Single word.** DBIT=8, SB_TICK=16, `s_tick`=1 every cycle; present 0xA5 with `fifo_empty` falling at cycle 0 → expected response:
   - `fifo_rd`=1 only in cycle 0.
   - `tx`=0 in cycles 1–16, then bits 1,0,1,0,0,1,0,1 for 16 cycles each (cycles 17–144).
   - `tx`=1 in cycles 145–160.
   - `tx_done_tick`=1 in cycle 160 only; `tx_busy`=0 from cycle 161.
3. **Back-to-back.** FIFO holding 0x00 then 0xFF, `s_tick` every 4th cycle → expected response:
   - Exactly two `fifo_rd` pulses; the second arrives one cycle after the first `tx_done_tick`.
   - Decoded frames are 0x00 and 0xFF with no framing error.
   - Each bit lasts 64 clk.
4. **Long stop.** SB_TICK=32, word 0x3C → stop period lasts 32 ticks; frame totals 176 ticks; data decodes as 0x3C.
5. **Reset mid-frame.** Assert `reset`=0 during data bit 3 → `tx`=1 and `tx_busy`=0 asynchronously, before the next `clk` edge. After release with `fifo_empty`=1, no pop and `tx` stays high.
6. **Stalls and pop discipline.** Hold `s_tick`=0 for 100 cycles inside START → `tx` stays 0 and the state is unchanged. Drive `fifo_empty`=0 throughout the frame → `fifo_rd` stays 0 until the cycle after `tx_done_tick`.

Source files
------------

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   Drains the read side of the TX FIFO. Each word is sent as one asynchronous
//   UART frame: a start bit, DBIT data bits LSB first, then a stop period of
//   SB_TICK baud ticks. Every bit is timed from the shared 16x oversampling
//   tick.
//
// Parameters
//   DBIT     data bits per frame (6..9)
//   SB_TICK  stop period in s_tick units (16 = 1, 24 = 1.5, 32 = 2 stop bits)
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   s_tick        one-clk pulse at 16x the baud rate
//   fifo_empty    FIFO empty flag
//   fifo_r_data   FIFO head word, valid while fifo_empty = 0
//   fifo_rd       one-cycle pop strobe, only ever asserted in IDLE
//   tx            registered serial line, idles high
//   tx_busy       high while a frame is in progress (state != IDLE)
//   tx_done_tick  one-cycle pulse on the final tick of the stop period
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_r_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  // The tick counter covers both the 16-tick bit period and the stop period.
  localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int SW    = $clog2(S_MAX + 1);
  localparam int NW    = $clog2(DBIT);

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_s;
  logic [NW-1:0]   r_n;
  logic [DBIT-1:0] r_b;
  logic            r_tx;

  logic            w_pop;
  logic            w_bit_end;
  logic            w_stop_end;

  // Popping is the commitment to send: it only happens from IDLE.
  assign w_pop      = (r_state == IDLE) & ~fifo_empty;
  assign w_bit_end  = s_tick & (r_s == S_BIT_LAST);
  assign w_stop_end = (r_state == STOP) & s_tick & (r_s == S_STOP_LAST);

  // r_tx is loaded with the level the *next* state drives, so the line
  // changes exactly on the state transition edge and never glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_tx    <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          // A tick coinciding with the pop is deliberately not counted.
          if (w_pop) begin
            r_b     <= fifo_r_data;
            r_s     <= '0;
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end

        START: begin
          if (s_tick) begin
            if (w_bit_end) begin
              r_s     <= '0;
              r_n     <= '0;
              r_tx    <= r_b[0];
              r_state <= DATA;
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (w_bit_end) begin
              r_s <= '0;
              r_b <= r_b >> 1;
              if (r_n == N_LAST) begin
                r_tx    <= 1'b1;
                r_state <= STOP;
              end else begin
                // r_b[1] is the bit that lands in r_b[0] after this shift.
                r_n  <= r_n + NW'(1);
                r_tx <= r_b[1];
              end
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end

        STOP: begin
          if (s_tick) begin
            if (r_s == S_STOP_LAST) begin
              r_state <= IDLE;
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end

        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign fifo_rd      = w_pop;
  assign tx           = r_tx;
  assign tx_busy      = (r_state != IDLE);
  assign tx_done_tick = w_stop_end;

endmodule
